// File: rtl/fifo_pop_arbiter_pkg.sv
`default_nettype none
// fifo_pop_arbiter_pkg: transaction-layer state encodings, arbiter FSM encodings and helpers.
// Revision 1.0
package fifo_pop_arbiter_pkg;

  localparam logic [3:0] ST_RESET  = 4'b0001;
  localparam logic [3:0] ST_INIT   = 4'b0010;
  localparam logic [3:0] ST_IDLE   = 4'b0100;
  localparam logic [3:0] ST_ACTIVE = 4'b1000;

  localparam logic [1:0] FSM_OFF   = 2'd0;
  localparam logic [1:0] FSM_RUN   = 2'd1;
  localparam logic [1:0] FSM_PAUSE = 2'd2;

  function automatic logic [2:0] onehot8_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_pop_arbiter_if.sv
`default_nettype none
// fifo_pop_arbiter_if: VC FIFO heads, downstream credit return and forwarded-word bundle.
// Revision 1.0
interface fifo_pop_arbiter_if #(
  parameter int DATA_W = 10
);
  logic [3:0]          State;
  logic [2:0]          umbral_superior;
  logic [2:0]          umbral_inferior;
  logic [7:0]          empty;
  logic [8*DATA_W-1:0] data_in;
  logic                ds_pop;
  logic [7:0]          pop;
  logic [DATA_W-1:0]   data_out;
  logic                valid_out;
  logic [3:0]          count;
  logic                paused;

  modport master (
    output State, umbral_superior, umbral_inferior, empty, data_in, ds_pop,
    input  pop, data_out, valid_out, count, paused
  );

  modport slave (
    input  State, umbral_superior, umbral_inferior, empty, data_in, ds_pop,
    output pop, data_out, valid_out, count, paused
  );
endinterface
`default_nettype wire

// File: rtl/fifo_pop_arbiter_rr.sv
`default_nettype none
// rr_arbiter8: grants the first requester after ptr, wrapping modulo 8; ptr itself is checked last.
// Revision 1.0
module rr_arbiter8 (
  input  logic [7:0] req,
  input  logic [2:0] ptr,
  output logic [7:0] grant
);
  logic [2:0] idx;
  logic       found;

  always_comb begin
    grant = 8'd0;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fifo_pop_arbiter.sv
`default_nettype none
// fifo_pop_arbiter: round-robin pops from eight show-ahead VC FIFOs into a threshold-paused downstream buffer.
// Revision 1.0
module fifo_pop_arbiter
  import fifo_pop_arbiter_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  fifo_pop_arbiter_if.slave bus
);
  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  logic [1:0]        fsm_q, fsm_d;
  logic [3:0]        count_q;
  logic [2:0]        ptr_q, grant_idx;
  logic [7:0]        grant, pop_w;
  logic [DATA_W-1:0] data_q;
  logic              valid_q, active, pause_hit, resume_hit;
  logic              grant_en, any_grant, drain, paused_w;

  assign active     = (bus.State == ST_ACTIVE);
  assign pause_hit  = (bus.umbral_superior != 3'd0) && (count_q >= {1'b0, bus.umbral_superior});
  assign resume_hit = (count_q <= {1'b0, bus.umbral_inferior});
  assign drain      = bus.ds_pop && (count_q != 4'd0);
  assign any_grant  = |pop_w;
  assign grant_idx  = onehot8_idx(pop_w);

  rr_arbiter8 u_rr (
    .req   (~bus.empty),
    .ptr   (ptr_q),
    .grant (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) fsm_q <= FSM_OFF;
    else       fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      FSM_OFF:   if (active) fsm_d = FSM_RUN;
      FSM_RUN:   if (!active) fsm_d = FSM_OFF;
                 else if (pause_hit) fsm_d = FSM_PAUSE;
      FSM_PAUSE: if (!active) fsm_d = FSM_OFF;
                 else if (resume_hit) fsm_d = FSM_RUN;
      default:   fsm_d = FSM_OFF;
    endcase
  end

  // A RUN cycle that is about to pause issues no pop, so occupancy stops at the threshold.
  always_comb begin
    grant_en = !reset && (fsm_q == FSM_RUN) && active && !pause_hit && (count_q < DEPTH_C);
    pop_w    = grant_en ? grant : 8'd0;
    paused_w = (fsm_q == FSM_PAUSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= 4'd0;
      ptr_q   <= 3'd7;
    end else begin
      valid_q <= any_grant;
      if (any_grant) begin
        data_q <= bus.data_in[grant_idx*DATA_W +: DATA_W];
        ptr_q  <= grant_idx;
      end
      case ({any_grant, drain})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign bus.pop       = pop_w;
  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.count     = count_q;
  assign bus.paused    = paused_w;
endmodule
`default_nettype wire

// File: doc/fifo_pop_arbiter.md
FIFO_POP_ARBITER -- requirements
Module: fifo_pop_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 10, width of each virtual-channel word.
REQ-002 SHALL have parameter DEPTH, default 8, downstream buffer capacity in words.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 State  input  4  one-hot transaction-layer state: RESET/INIT/IDLE/ACTIVE.
REQ-007 umbral_superior  input  3  pause threshold, latched upstream.
REQ-008 umbral_inferior  input  3  resume threshold, latched upstream.
REQ-009 empty  input  8  per-VC FIFO empty flags, bit i = FIFO i.
REQ-010 data_in  input  8*DATA_W  show-ahead FIFO heads; FIFO i at bits [i*DATA_W +: DATA_W].
REQ-011 ds_pop  input  1  downstream consumer removed one word.
REQ-012 pop  output  8  one-hot pop strobe to VC FIFOs, at most one bit set.
REQ-013 data_out  output  DATA_W  forwarded word.
REQ-014 valid_out  output  1  data_out qualifier.
REQ-015 count  output  4  downstream occupancy, 0..DEPTH.
REQ-016 paused  output  1  high while in PAUSE.

Function
REQ-017 SHALL implement FSM states OFF, RUN and PAUSE.
REQ-018 OFF->RUN when State==ACTIVE.
REQ-019 RUN/PAUSE->OFF when State!=ACTIVE; an in-flight word still completes.
REQ-020 RUN->PAUSE when registered count >= umbral_superior and umbral_superior != 0.
REQ-021 PAUSE->RUN when count <= umbral_inferior.
REQ-022 umbral_superior==0 SHALL disable pausing.
REQ-023 pop SHALL be combinational and nonzero only in RUN, with State==ACTIVE, count<DEPTH and at least one empty bit low.
REQ-024 Grant SHALL be round-robin: search starts at last-granted index +1 mod 8, lowest index first after reset; the pointer updates only on a grant.
REQ-025 Latency SHALL be 1 cycle: a word selected with pop[i] at cycle N appears on data_out with valid_out=1 at cycle N+1.
REQ-026 valid_out SHALL be 0 on cycles following no grant; data_out holds its last value.
REQ-027 count SHALL increment on a grant edge and decrement on ds_pop; simultaneous events leave it unchanged.
REQ-028 ds_pop at count==0 SHALL be ignored; a grant SHALL never be issued at count==DEPTH.
REQ-029 A FIFO whose empty bit rises in the same cycle SHALL NOT be popped.
REQ-030 umbral_inferior > umbral_superior SHALL behave per REQ-020/021 literally, with no special case.

Reset
REQ-031 reset SHALL override all other inputs for that cycle.
REQ-032 On reset: FSM=OFF, pop=0, valid_out=0, data_out=0, count=0, paused=0, round-robin pointer=7.
REQ-033 Reset mid-transfer SHALL discard the in-flight word; no valid_out on the following cycle.

Structure
REQ-034 One-hot State encodings (RESET 0001, INIT 0010, IDLE 0100, ACTIVE 1000) and the FSM encodings SHALL live in the shared transaction-layer parameter include.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter8 (req[7:0], ptr, grant[7:0]).

Verification
REQ-036 Reset, State=ACTIVE, empty=8'hFE -> pop=8'h01 each eligible cycle; valid_out next cycle with data_in[0 +: 10].
REQ-037 empty=8'h00, thresholds 7/0, ds_pop=1 every cycle -> pop sequence 01,02,04,...,80,01; count stays 1.
REQ-038 umbral_superior=3, umbral_inferior=1, no ds_pop -> three pops, then paused=1 with count=3; two ds_pop -> count=1, RUN, pops resume.
REQ-039 State switches ACTIVE->IDLE during pop -> word delivered next cycle; no further pop; FSM=OFF.
REQ-040 Grant and ds_pop on the same edge at count=2 -> count remains 2.
REQ-041 reset asserted the cycle after a grant -> valid_out=0, count=0, next grant goes to index 0.
